// File: rtl/linear_sched_pkg.sv
// linear_sched_pkg: shared types and defaults for the linear engine scheduler.
// Holds the FSM state enum, default sizing constants and a small wrap helper.
package linear_sched_pkg;

    // Default number of requesters (Q/K/V projections).
    localparam int LS_NUM_REQ     = 3;

    // Default watchdog limit in WAIT cycles.
    localparam int LS_TIMEOUT_CYC = 1024;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRANT = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        ACK   = 3'd4
    } sched_state_t;

    // Next index after idx in a ring of n entries.
    function automatic int ls_wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational rotate-priority pick of the first eligible
// requester at or above ptr, wrapping at NUM_REQ.
// Ports: req/mask (NUM_REQ) in, ptr (IDX_W) in, any out, idx (IDX_W) out.
module rr_arbiter
    import linear_sched_pkg::*;
#(
    parameter int NUM_REQ = LS_NUM_REQ,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any,
    output logic [IDX_W-1:0]   idx
);

    localparam logic [IDX_W:0] NREQ = (IDX_W + 1)'(NUM_REQ);

    logic [NUM_REQ-1:0]   w_elig;
    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [IDX_W-1:0]     w_off;
    logic [IDX_W:0]       w_sum;

    assign w_elig = req & mask;

    // Rotate so bit k of w_rot is requester (ptr + k) mod NUM_REQ.
    assign w_dbl = {w_elig, w_elig} >> ptr;
    assign w_rot = w_dbl[NUM_REQ-1:0];

    // Lowest set bit of the rotated vector is the winner's offset.
    always_comb begin
        w_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = IDX_W'(k);
            end
        end
    end

    assign w_sum = {1'b0, ptr} + {1'b0, w_off};
    assign any   = |w_rot;
    assign idx   = (w_sum >= NREQ) ? IDX_W'(w_sum - NREQ)
                                   : w_sum[IDX_W-1:0];

endmodule

// File: rtl/linear_sched.sv
// linear_sched: round-robin scheduler time-sharing one linear engine among
// NUM_REQ requesters. Optional watchdog enabled by LINEAR_SCHED_TIMEOUT_EN.
// Ports: clk, reset (sync, active-low), req/ack (NUM_REQ), grant_valid,
// grant_idx (IDX_W), busy, eng_start, eng_done, err.
module linear_sched
    import linear_sched_pkg::*;
#(
    parameter int NUM_REQ     = LS_NUM_REQ,
    parameter int IDX_W       = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYC = LS_TIMEOUT_CYC
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] ack,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               busy,
    output logic               eng_start,
    input  logic               eng_done,
    output logic               err
);

    sched_state_t r_state;
    sched_state_t w_state_nxt;

    logic [IDX_W-1:0]   r_grant_idx;
    logic [IDX_W-1:0]   r_ptr;
    logic               r_wait_first;
    logic [IDX_W-1:0]   w_ptr_inc;
    logic [IDX_W-1:0]   w_arb_ptr;
    logic [IDX_W-1:0]   w_arb_idx;
    logic [NUM_REQ-1:0] w_served;
    logic [NUM_REQ-1:0] w_arb_mask;
    logic               w_arb_any;
    logic               w_load;

    assign w_served  = NUM_REQ'(1) << r_grant_idx;
    assign w_ptr_inc = IDX_W'(ls_wrap_inc(int'(r_grant_idx), NUM_REQ));

    // In ACK the served requester still holds req, so it is masked and
    // the search starts just past it.
    assign w_arb_ptr  = (r_state == ACK) ? w_ptr_inc : r_ptr;
    assign w_arb_mask = (r_state == ACK) ? ~w_served : '1;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req  (req),
        .mask (w_arb_mask),
        .ptr  (w_arb_ptr),
        .any  (w_arb_any),
        .idx  (w_arb_idx)
    );

`ifdef LINEAR_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic             w_expired;
    logic             w_to;

    assign w_expired = (r_cnt == CNT_W'(TIMEOUT_CYC));

    // Counter is zero in the first WAIT cycle and counts WAIT cycles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_to;
            if (r_state == START) begin
                r_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // r_err is only set on the WAIT->ACK timeout edge, so it lines up with ack.
    assign err = r_err;
`else
    logic w_unused_cfg;

    assign w_unused_cfg = (TIMEOUT_CYC > 0);
    assign err          = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_grant_idx  <= '0;
            r_ptr        <= '0;
            r_wait_first <= 1'b0;
        end else begin
            // High only in the first WAIT cycle, to blank a stale held done.
            r_wait_first <= (r_state == START);
            if (r_state == ACK) begin
                r_ptr <= w_ptr_inc;
            end
            if (w_load) begin
                r_grant_idx <= w_arb_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        ack         = '0;
        busy        = 1'b1;
        grant_valid = 1'b1;
        eng_start   = 1'b0;
`ifdef LINEAR_SCHED_TIMEOUT_EN
        w_to        = 1'b0;
`endif
        unique case (r_state)
            IDLE: begin
                busy        = 1'b0;
                grant_valid = 1'b0;
                if (w_arb_any) begin
                    w_load      = 1'b1;
                    w_state_nxt = GRANT;
                end
            end
            GRANT: begin
                w_state_nxt = START;
            end
            START: begin
                eng_start   = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (!r_wait_first && eng_done) begin
                    w_state_nxt = ACK;
                end
`ifdef LINEAR_SCHED_TIMEOUT_EN
                else if (w_expired) begin
                    w_state_nxt = ACK;
                    w_to        = 1'b1;
                end
`endif
            end
            ACK: begin
                ack = w_served;
                if (w_arb_any) begin
                    w_load      = 1'b1;
                    w_state_nxt = GRANT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                busy        = 1'b0;
                grant_valid = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign grant_idx = r_grant_idx;

endmodule

// File: tb/tb_linear_sched.sv
// tb_linear_sched: self-checking bench for linear_sched with a
// transaction-timestamp reference model, vector table and corner sequences.
module tb_linear_sched;

    localparam int N  = 3;
    localparam int TO = 16;

    typedef struct {
        logic [N-1:0] r;
        logic         d;
        logic [8:0]   e;
    } vec_t;

    logic         clk      = 1'b0;
    logic         reset    = 1'b0;
    logic [N-1:0] req      = '0;
    logic         eng_done = 1'b0;
    logic [N-1:0] ack;
    logic         grant_valid;
    logic [1:0]   grant_idx;
    logic         busy;
    logic         eng_start;
    logic         err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model: current transaction occupies cycles m_g .. m_ack.
    int m_g   = -1;
    int m_ack = -1;
    int m_idx = 0;
    int m_ptr = 0;
    bit m_err = 1'b0;

    // {ack[2:0], grant_valid, grant_idx[1:0], busy, eng_start, err}
    logic [8:0] obs_raw;
    int ack_i_q[$];
    int ack_c_q[$];
    int st_c_q[$];

    always #5 clk = ~clk;

    linear_sched #(
        .NUM_REQ     (N),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .ack         (ack),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .busy        (busy),
        .eng_start   (eng_start),
        .eng_done    (eng_done),
        .err         (err)
    );

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        int rv;
        int j;
        rv = int'(r);
        for (int k = 0; k < N; k++) begin
            j = (p + k) % N;
            if (((rv >> j) & 1) == 1) return j;
        end
        return -1;
    endfunction

    function automatic logic [8:0] mexp();
        logic [8:0] e;
        e = '0;
        if (m_g >= 0 && cyc >= m_g) begin
            e[5]   = 1'b1;
            e[4:3] = 2'(m_idx);
            e[2]   = 1'b1;
            e[1]   = (cyc == m_g + 1);
            if (cyc == m_ack) begin
                e[8:6] = 3'(1 << m_idx);
                e[0]   = m_err;
            end
        end
        return e;
    endfunction

    task automatic mstep(input logic [N-1:0] r, input logic d, input logic rn);
        logic [N-1:0] pend;
        if (!rn) begin
            m_g   = -1;
            m_ack = -1;
            m_ptr = 0;
            m_err = 1'b0;
            return;
        end
        if (m_g >= 0 && cyc >= m_g) begin
            if (cyc == m_ack) begin
                m_ptr = (m_idx + 1) % N;
                pend  = r & ~N'(1 << m_idx);
                if (pend != '0) begin
                    m_idx = pick(pend, m_ptr);
                    m_g   = cyc + 1;
                    m_ack = -1;
                    m_err = 1'b0;
                end else begin
                    m_g = -1;
                end
            end else if (m_ack < 0) begin
                if (d && cyc >= m_g + 3) begin
                    m_ack = cyc + 1;
                end
`ifdef LINEAR_SCHED_TIMEOUT_EN
                else if (cyc == m_g + 2 + TO) begin
                    m_ack = cyc + 1;
                    m_err = 1'b1;
                end
`endif
            end
        end else if (m_g < 0 && r != '0) begin
            m_idx = pick(r, m_ptr);
            m_g   = cyc + 1;
            m_ack = -1;
            m_err = 1'b0;
        end
    endtask

    task automatic tick(input logic [N-1:0] r, input logic d, input logic rn);
        logic [8:0] e;
        logic [8:0] a;
        req      = r;
        eng_done = d;
        reset    = rn;
        @(negedge clk);
        obs_raw = {ack, grant_valid, grant_idx, busy, eng_start, err};
        e = mexp();
        a = obs_raw;
        if (!e[5]) a[4:3] = e[4:3];
        check("model", 32'(a), 32'(e));
        if (obs_raw[1]) st_c_q.push_back(cyc);
        for (int i = 0; i < N; i++) begin
            if (obs_raw[6+i]) begin
                ack_i_q.push_back(i);
                ack_c_q.push_back(cyc);
            end
        end
        mstep(r, d, rn);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input logic d);
        for (int k = 0; k < 3; k++) tick('0, d, 1'b0);
        check("reset_state", 32'(obs_raw), 32'd0);
        ack_i_q.delete();
        ack_c_q.delete();
        st_c_q.delete();
    endtask

    // Requesters hold until ack and drop the cycle after; engine pulses
    // done lat cycles after each observed start.
    task automatic run(input int n, input int pct, input int lmin, input int lmax);
        logic [N-1:0] hold;
        logic [N-1:0] cool;
        int           done_at;
        hold    = req;
        cool    = '0;
        done_at = -1;
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!hold[i] && !cool[i] && int'($urandom_range(99)) < pct)
                    hold[i] = 1'b1;
            end
            tick(hold, cyc == done_at, 1'b1);
            cool = '0;
            if (obs_raw[1])
                done_at = cyc - 1 + int'($urandom_range(lmax, lmin));
            for (int i = 0; i < N; i++) begin
                if (obs_raw[6+i]) begin
                    hold[i] = 1'b0;
                    cool[i] = 1'b1;
                end
            end
        end
    endtask

    initial begin
        vec_t       tab[13];
        logic [8:0] a;
        int         got_a;
        int         got_s;
        int         nack;
        logic [2:0] ack_v;
        logic       bsy;
        logic       errs;
        int         exp_order[4];

        for (int i = 0; i < 13; i++) begin
            tab[i].r = (i < 12) ? 3'b001 : 3'b000;
            tab[i].d = (i == 10);
            tab[i].e = (i >= 1 && i <= 10) ? 9'b000_1_00_1_0_0 : 9'b0;
        end
        tab[2].e  = 9'b000_1_00_1_1_0;
        tab[11].e = 9'b001_1_00_1_0_0;

        exp_order[0] = 0;
        exp_order[1] = 1;
        exp_order[2] = 2;
        exp_order[3] = 0;

        @(posedge clk);
        #1;

        // Single request, done at cycle 10.
        do_reset(1'b0);
        for (int i = 0; i < 13; i++) begin
            tick(tab[i].r, tab[i].d, 1'b1);
            a = obs_raw;
            if (!tab[i].e[5]) a[4:3] = 2'b00;
            check("table_single", 32'(a), 32'(tab[i].e));
        end

        // All requesting: round-robin order and start spacing.
        do_reset(1'b0);
        run(30, 100, 3, 3);
        check("rr_count_ok", 32'(ack_i_q.size() >= 4), 32'd1);
        if (ack_i_q.size() >= 4 && st_c_q.size() >= 4) begin
            for (int k = 0; k < 4; k++)
                check("rr_order", 32'(ack_i_q[k]), 32'(exp_order[k]));
            for (int k = 1; k < 4; k++)
                check("rr_start_gap", 32'(st_c_q[k] - ack_c_q[k-1]), 32'd2);
        end

        // Stale done held from reset through the first WAIT cycle.
        do_reset(1'b1);
        got_a = -1;
        for (int k = 0; k < 12; k++) begin
            tick((k <= 9) ? 3'b001 : 3'b000, (k <= 3) || (k == 8), 1'b1);
            if (obs_raw[8:6] != '0 && got_a < 0) got_a = k;
        end
        check("stale_done_ack_cyc", 32'(got_a), 32'd9);

        // Reset during WAIT drops the transaction.
        do_reset(1'b0);
        for (int k = 0; k < 5; k++) tick(3'b001, 1'b0, 1'b1);
        tick(3'b001, 1'b0, 1'b0);
        tick(3'b000, 1'b0, 1'b1);
        check("midrst_outputs", 32'(obs_raw), 32'd0);
        got_a = -1;
        got_s = -1;
        ack_v = '0;
        for (int k = 0; k < 10; k++) begin
            tick((k <= 7) ? 3'b010 : 3'b000, k == 6, 1'b1);
            if (obs_raw[1] && got_s < 0) got_s = k;
            if (obs_raw[8:6] != '0 && got_a < 0) begin
                got_a = k;
                ack_v = obs_raw[8:6];
            end
        end
        check("midrst_start_cyc", 32'(got_s), 32'd2);
        check("midrst_ack_cyc", 32'(got_a), 32'd7);
        check("midrst_ack_val", 32'(ack_v), 32'b010);

        // Requester drops during WAIT; ack still pulses.
        do_reset(1'b0);
        got_a = -1;
        ack_v = '0;
        bsy   = 1'b1;
        for (int k = 0; k < 11; k++) begin
            tick((k <= 3) ? 3'b100 : 3'b000, k == 7, 1'b1);
            if (obs_raw[8:6] != '0 && got_a < 0) begin
                got_a = k;
                ack_v = obs_raw[8:6];
            end
            if (k == 9) bsy = obs_raw[2];
        end
        check("drop_ack_cyc", 32'(got_a), 32'd8);
        check("drop_ack_val", 32'(ack_v), 32'b100);
        check("drop_idle_after", 32'(bsy), 32'd0);

        // Engine never finishes.
        do_reset(1'b0);
        got_a = -1;
        nack  = 0;
        errs  = 1'b0;
`ifdef LINEAR_SCHED_TIMEOUT_EN
        for (int k = 0; k < 24; k++) begin
            tick((got_a < 0) ? 3'b001 : 3'b000, 1'b0, 1'b1);
            if (obs_raw[8:6] != '0 && got_a < 0) begin
                got_a = k;
                errs  = obs_raw[0];
            end
        end
        check("timeout_ack_cyc", 32'(got_a), 32'd20);
        check("timeout_err", 32'(errs), 32'd1);
`else
        for (int k = 0; k < 100; k++) begin
            tick(3'b001, 1'b0, 1'b1);
            if (obs_raw[8:6] != '0) nack++;
            errs = errs | obs_raw[0];
        end
        check("hang_no_ack", 32'(nack), 32'd0);
        check("hang_no_err", 32'(errs), 32'd0);
`endif

        // Random traffic against the model.
        do_reset(1'b0);
        run(3000, 25, 2, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
